// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding and default line settings.
// Parity support in uart_tx is selected with `UART_TX_PARITY_EN.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned UART_CLK_FREQ_DEFAULT = 50_000_000;
    localparam int unsigned UART_BAUD_DEFAULT     = 115_200;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered tx/busy/done outputs.
// Define `UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = UART_CLK_FREQ_DEFAULT,
    parameter int unsigned BAUD         = UART_BAUD_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       snd_flag,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    uart_state_e state, state_n;
    logic [7:0]  shift, shift_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        tx_n, busy_n, done_n;
    logic        bit_tick, baud_clear;
`ifdef UART_TX_PARITY_EN
    logic        parity, parity_n;
`endif

    // Counter is held at zero while idle so every frame starts on a fresh bit period.
    assign baud_clear = (state == UART_IDLE);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= UART_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

    // Outputs are computed for the next state so they leave registers aligned with it.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        tx_n      = tx;
        busy_n    = busy;
        done_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n  = parity;
`endif
        case (state)
            UART_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (snd_flag) begin
                    shift_n = data;
`ifdef UART_TX_PARITY_EN
                    parity_n = even_parity(data);
`endif
                    state_n = UART_START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            UART_START: begin
                if (bit_tick) begin
                    state_n   = UART_DATA;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                end
            end
            UART_DATA: begin
                if (bit_tick) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = UART_PARITY;
                        tx_n    = parity;
`else
                        state_n = UART_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        tx_n = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (bit_tick) begin
                    state_n = UART_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            UART_STOP: begin
                if (bit_tick) begin
                    state_n = UART_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = UART_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=8; honours `UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int unsigned CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
    localparam logic [NB-1:0] LIT_55 = 11'b1_0_01010101_0;
    localparam logic [NB-1:0] LIT_A3 = 11'b1_0_10100011_0;
    localparam logic [NB-1:0] LIT_07 = 11'b1_1_00000111_0;
    localparam logic [NB-1:0] LIT_0F = 11'b1_0_00001111_0;
    localparam logic [NB-1:0] LIT_81 = 11'b1_0_10000001_0;
`else
    localparam int unsigned NB = 10;
    localparam logic [NB-1:0] LIT_55 = 10'b1_01010101_0;
    localparam logic [NB-1:0] LIT_A3 = 10'b1_10100011_0;
    localparam logic [NB-1:0] LIT_07 = 10'b1_00000111_0;
    localparam logic [NB-1:0] LIT_0F = 10'b1_00001111_0;
    localparam logic [NB-1:0] LIT_81 = 10'b1_10000001_0;
`endif
    localparam int unsigned DONE_OFF = NB * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       snd_flag = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, busy, done;

    uart_tx #(
        .CLK_FREQ(8),
        .BAUD(1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .snd_flag (snd_flag),
        .data     (data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a frame is NB bits of CPB cycles each, counted from the cycle after acceptance.
    logic              m_active = 1'b0;
    logic              m_done   = 1'b0;
    int unsigned       m_pos    = 0;
    logic [NB-1:0]     m_frame  = '1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_pos    <= 0;
        end else if (m_active) begin
            if (m_pos == DONE_OFF - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_pos  <= m_pos + 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (snd_flag) begin
                m_active <= 1'b1;
                m_pos    <= 0;
`ifdef UART_TX_PARITY_EN
                m_frame  <= {1'b1, ^data, data, 1'b0};
`else
                m_frame  <= {1'b1, data, 1'b0};
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("cyc_tx", tx, m_active ? m_frame[m_pos / CPB] : 1'b1);
            check("cyc_busy", busy, m_active);
            check("cyc_done", done, m_done);
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    // Sends one byte, checks mid-bit literals, and returns at the negedge of the done cycle.
    task automatic run_frame(input logic [7:0] d, input logic [NB-1:0] lit,
                             input bit inject, input string tag);
        int unsigned off;
        data     = d;
        snd_flag = 1'b1;
        @(posedge clock);
        #2;
        snd_flag = 1'b0;
        @(negedge clock);
        off = 0;
        check({tag, "_start_tx"}, tx, 1'b0);
        check({tag, "_start_busy"}, busy, 1'b1);
        for (int unsigned b = 0; b < NB; b++) begin
            repeat (b * CPB + CPB / 2 - off) @(negedge clock);
            off = b * CPB + CPB / 2;
            check($sformatf("%s_bit%0d", tag, b), tx, lit[b]);
            if (inject && b == 2) begin
                data     = 8'hFF;
                snd_flag = 1'b1;
                @(negedge clock);
                off++;
                snd_flag = 1'b0;
            end
        end
        while (done !== 1'b1 && off < DONE_OFF + 40) begin
            @(negedge clock);
            off++;
        end
        check_int({tag, "_done_offset"}, int'(off), int'(DONE_OFF));
    endtask

    initial begin
        int unsigned d0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;

        @(negedge clock);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        repeat (100) @(negedge clock);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", busy, 1'b0);
        check_int("idle_done_count", int'(done_cnt), 0);

        run_frame(8'h55, LIT_55, 1'b0, "f55");
        repeat (5) @(negedge clock);

        d0 = done_cnt;
        run_frame(8'hA3, LIT_A3, 1'b1, "fA3");
        repeat (30) @(negedge clock);
        check_int("ignore_done_count", int'(done_cnt - d0), 1);
        check("ignore_idle_tx", tx, 1'b1);

        // Second request issued in the done cycle of the first.
        run_frame(8'h07, LIT_07, 1'b0, "f07");
        run_frame(8'h0F, LIT_0F, 1'b0, "f0F");
        repeat (5) @(negedge clock);

        data     = 8'h00;
        snd_flag = 1'b1;
        @(posedge clock);
        #2;
        snd_flag = 1'b0;
        @(negedge clock);
        repeat (35) @(negedge clock);
        check("rst_mid_pre_tx", tx, 1'b0);
        check("rst_mid_pre_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        d0 = done_cnt;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (60) @(negedge clock);
        check_int("rst_no_done", int'(done_cnt - d0), 0);

        run_frame(8'h81, LIT_81, 1'b0, "f81");
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
